// File: rtl/fifo_flagged_pkg.sv
// Shared defaults and the per-cycle operation encoding for the flagged FIFO.
package fifo_flagged_pkg;

    localparam int DEFAULT_FIFO_SIZE       = 16;
    localparam int DEFAULT_FIFO_WORD_WIDTH = 8;

    // Encoding is {wr_ok, rd_ok}, so an accept pair casts straight into a state.
    typedef enum logic [1:0] {
        FIFO_STATE_IDLE           = 2'b00,
        FIFO_STATE_READ           = 2'b01,
        FIFO_STATE_WRITE          = 2'b10,
        FIFO_STATE_READ_AND_WRITE = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_flagged_ptr.sv
// Wrapping FIFO pointer: counts 0..FIFO_SIZE-1 and wraps explicitly, so any depth works.
module fifo_flagged_ptr
#(
    parameter int FIFO_SIZE = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(FIFO_SIZE)-1:0] ptr
);

    localparam int PW = $clog2(FIFO_SIZE);
    localparam logic [PW-1:0] LAST = PW'(FIFO_SIZE - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module fifo_flagged
    import fifo_flagged_pkg::*;
#(
    parameter int FIFO_SIZE    = DEFAULT_FIFO_SIZE,
    parameter int WORD_WIDTH   = DEFAULT_FIFO_WORD_WIDTH,
    parameter int AFULL_LEVEL  = FIFO_SIZE - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           clr_err,
    input  logic [WORD_WIDTH-1:0]          w_data,
    input  logic                           wr,
    input  logic                           rd,
    output logic [WORD_WIDTH-1:0]          r_data,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(FIFO_SIZE+1)-1:0] count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PW = $clog2(FIFO_SIZE);
    localparam int CW = $clog2(FIFO_SIZE + 1);

    logic [WORD_WIDTH-1:0] mem [FIFO_SIZE];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    fifo_op_e              op;
    logic [CW-1:0]         count_next;

    // A write into a full FIFO is allowed only when a pop frees the slot this cycle.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_comb begin
        count_next = count;
        case (op)
            FIFO_STATE_WRITE: count_next = count + CW'(1);
            FIFO_STATE_READ:  count_next = count - CW'(1);
            default:          count_next = count;
        endcase
    end

    fifo_flagged_ptr #(.FIFO_SIZE(FIFO_SIZE)) u_w_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (wr_ok),
        .ptr   (w_ptr)
    );

    fifo_flagged_ptr #(.FIFO_SIZE(FIFO_SIZE)) u_r_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (rd_ok),
        .ptr   (r_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_ok && !reset && !flush) begin
            mem[w_ptr] <= w_data;
        end
    end

    assign r_data = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                // AFULL_LEVEL >= 1 and AEMPTY_LEVEL >= 0, so the count-0 flags are fixed.
                count        <= '0;
                empty        <= 1'b1;
                almost_empty <= 1'b1;
                full         <= 1'b0;
                almost_full  <= 1'b0;
            end else begin
                count        <= count_next;
                empty        <= (count_next == '0);
                full         <= (count_next == CW'(FIFO_SIZE));
                almost_full  <= (count_next >= CW'(AFULL_LEVEL));
                almost_empty <= (count_next <= CW'(AEMPTY_LEVEL));
            end
            // A new error in the same cycle as clr_err leaves the flag set.
            overflow  <= (overflow  & ~clr_err) | (wr & ~wr_ok & ~flush);
            underflow <= (underflow & ~clr_err) | (rd & ~rd_ok & ~flush);
        end
    end

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_fifo_flagged;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, flush_a, clr_a, wr_a, rd_a;
    logic [7:0] wdata_a, rdata_a;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [2:0] count_a;

    logic       reset_b, flush_b, clr_b, wr_b, rd_b;
    logic [7:0] wdata_b, rdata_b;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0] count_b;

    fifo_flagged #(.FIFO_SIZE(6), .WORD_WIDTH(8), .AFULL_LEVEL(5), .AEMPTY_LEVEL(1)) dut_a (
        .clk(clk), .reset(reset_a), .flush(flush_a), .clr_err(clr_a), .w_data(wdata_a),
        .wr(wr_a), .rd(rd_a), .r_data(rdata_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    fifo_flagged #(.FIFO_SIZE(5), .WORD_WIDTH(8), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) dut_b (
        .clk(clk), .reset(reset_b), .flush(flush_b), .clr_err(clr_b), .w_data(wdata_b),
        .wr(wr_b), .rd(rd_b), .r_data(rdata_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    wire [8:0] stat_a = {count_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a};
    wire [8:0] stat_b = {count_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b};

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit ovfa, unfa, ovfb, unfb;

    // Expected {count, full, empty, almost_full, almost_empty, overflow, underflow}.
    function automatic logic [8:0] exp_status(int n, int size, int afl, int ael, bit o, bit u);
        return {3'(n), n == size, n == 0, n >= afl, n <= ael, o, u};
    endfunction

    task automatic cyc_a(input bit rs, input bit fl, input bit ce, input bit w, input bit r,
                         input logic [7:0] d);
        bit rok, wok;
        reset_a = rs; flush_a = fl; clr_a = ce; wr_a = w; rd_a = r; wdata_a = d;
        @(posedge clk);
        #1;
        if (rs) begin
            qa.delete(); ovfa = 0; unfa = 0;
        end else if (fl) begin
            qa.delete();
            if (ce) begin ovfa = 0; unfa = 0; end
        end else begin
            rok = r && (qa.size() != 0);
            wok = w && ((qa.size() != 6) || rok);
            if (rok) void'(qa.pop_front());
            if (wok) qa.push_back(d);
            ovfa = (ovfa && !ce) || (w && !wok);
            unfa = (unfa && !ce) || (r && !rok);
        end
        reset_a = 0; flush_a = 0; clr_a = 0; wr_a = 0; rd_a = 0;
    endtask

    task automatic cyc_b(input bit rs, input bit w, input bit r, input logic [7:0] d);
        bit rok, wok;
        reset_b = rs; flush_b = 0; clr_b = 0; wr_b = w; rd_b = r; wdata_b = d;
        @(posedge clk);
        #1;
        if (rs) begin
            qb.delete(); ovfb = 0; unfb = 0;
        end else begin
            rok = r && (qb.size() != 0);
            wok = w && ((qb.size() != 5) || rok);
            if (rok) void'(qb.pop_front());
            if (wok) qb.push_back(d);
            ovfb = ovfb || (w && !wok);
            unfb = unfb || (r && !rok);
        end
        reset_b = 0; wr_b = 0; rd_b = 0;
    endtask

    task automatic test_reset();
        cyc_a(1, 0, 0, 0, 0, 8'h00);
        cyc_b(1, 0, 0, 8'h00);
        compared++;
        if (stat_a !== 9'b000_0_1_0_1_0_0) begin
            mismatched++;
            $display("FAIL reset_a status: got %b want %b", stat_a, 9'b000_0_1_0_1_0_0);
        end
        compared++;
        if (stat_b !== 9'b000_0_1_0_1_0_0) begin
            mismatched++;
            $display("FAIL reset_b status: got %b want %b", stat_b, 9'b000_0_1_0_1_0_0);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 6; i++) begin
            cyc_a(0, 0, 0, 1, 0, 8'h11 + 8'(i));
            compared++;
            if (stat_a !== exp_status(i + 1, 6, 5, 1, 0, 0)) begin
                mismatched++;
                $display("FAIL fill status n=%0d: got %b want %b", i + 1, stat_a,
                         exp_status(i + 1, 6, 5, 1, 0, 0));
            end
        end
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (rdata_a !== 8'h11 + 8'(i)) begin
                mismatched++;
                $display("FAIL drain r_data %0d: got %h want %h", i, rdata_a, 8'h11 + 8'(i));
            end
            cyc_a(0, 0, 0, 0, 1, 8'h00);
            compared++;
            if (stat_a !== exp_status(5 - i, 6, 5, 1, 0, 0)) begin
                mismatched++;
                $display("FAIL drain status %0d: got %b want %b", i, stat_a,
                         exp_status(5 - i, 6, 5, 1, 0, 0));
            end
        end
    endtask

    task automatic test_full_wr_rd();
        for (int i = 0; i < 6; i++) cyc_a(0, 0, 0, 1, 0, 8'h01 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (rdata_a !== qa[0]) begin
                mismatched++;
                $display("FAIL full wr&rd head %0d: got %h want %h", i, rdata_a, qa[0]);
            end
            cyc_a(0, 0, 0, 1, 1, 8'h20 + 8'(i));
            compared++;
            if (stat_a !== exp_status(6, 6, 5, 1, 0, 0)) begin
                mismatched++;
                $display("FAIL full wr&rd status %0d: got %b want %b", i, stat_a,
                         exp_status(6, 6, 5, 1, 0, 0));
            end
        end
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (rdata_a !== 8'h24 + 8'(i)) begin
                mismatched++;
                $display("FAIL wrap order %0d: got %h want %h", i, rdata_a, 8'h24 + 8'(i));
            end
            cyc_a(0, 0, 0, 0, 1, 8'h00);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) cyc_a(0, 0, 0, 1, 0, 8'h40 + 8'(i));
        cyc_a(0, 0, 0, 1, 0, 8'hEE);
        compared++;
        if (stat_a !== exp_status(6, 6, 5, 1, 1, 0)) begin
            mismatched++;
            $display("FAIL overflow set: got %b want %b", stat_a, exp_status(6, 6, 5, 1, 1, 0));
        end
        compared++;
        if (rdata_a !== 8'h40) begin
            mismatched++;
            $display("FAIL overflow head kept: got %h want %h", rdata_a, 8'h40);
        end
        cyc_a(0, 0, 1, 0, 0, 8'h00);
        compared++;
        if (ovf_a !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_err overflow: got %b want 0", ovf_a);
        end
        cyc_a(0, 0, 1, 1, 0, 8'hEE);
        compared++;
        if (ovf_a !== 1'b1) begin
            mismatched++;
            $display("FAIL clr_err vs new overflow: got %b want 1", ovf_a);
        end
    endtask

    task automatic test_empty_wr_rd();
        cyc_a(0, 1, 1, 0, 0, 8'h00);
        cyc_a(0, 0, 0, 1, 1, 8'hA5);
        compared++;
        if (stat_a !== exp_status(1, 6, 5, 1, 0, 1)) begin
            mismatched++;
            $display("FAIL empty wr&rd status: got %b want %b", stat_a, exp_status(1, 6, 5, 1, 0, 1));
        end
        compared++;
        if (rdata_a !== 8'hA5) begin
            mismatched++;
            $display("FAIL empty wr&rd r_data: got %h want a5", rdata_a);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cyc_a(0, 0, 0, 1, 0, 8'h60 + 8'(i));
        cyc_a(0, 1, 0, 1, 1, 8'h77);
        compared++;
        if (stat_a !== exp_status(0, 6, 5, 1, 0, 1)) begin
            mismatched++;
            $display("FAIL flush status: got %b want %b", stat_a, exp_status(0, 6, 5, 1, 0, 1));
        end
        cyc_a(0, 0, 0, 1, 0, 8'h88);
        compared++;
        if (rdata_a !== 8'h88 || count_a !== 3'd1) begin
            mismatched++;
            $display("FAIL post-flush write: got %h/%0d want 88/1", rdata_a, count_a);
        end
    endtask

    task automatic test_size5();
        logic [7:0] d;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 5; i++) begin
                d = 8'($urandom);
                cyc_b(0, 1, 0, d);
                compared++;
                if (stat_b !== exp_status(i + 1, 5, 4, 1, 0, 0)) begin
                    mismatched++;
                    $display("FAIL size5 fill r%0d n=%0d: got %b want %b", round, i + 1, stat_b,
                             exp_status(i + 1, 5, 4, 1, 0, 0));
                end
            end
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (rdata_b !== qb[0]) begin
                    mismatched++;
                    $display("FAIL size5 data r%0d i%0d: got %h want %h", round, i, rdata_b, qb[0]);
                end
                cyc_b(0, 0, 1, 8'h00);
            end
            compared++;
            if (stat_b !== exp_status(0, 5, 4, 1, 0, 0)) begin
                mismatched++;
                $display("FAIL size5 drained r%0d: got %b want %b", round, stat_b,
                         exp_status(0, 5, 4, 1, 0, 0));
            end
        end
    endtask

    task automatic test_random();
        bit rs, fl, ce, w, r;
        for (int i = 0; i < 2000; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 59) == 0);
            ce = ($urandom_range(0, 19) == 0);
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            cyc_a(rs, fl, ce, w, r, 8'($urandom));
            compared++;
            if (stat_a !== exp_status(qa.size(), 6, 5, 1, ovfa, unfa)) begin
                mismatched++;
                $display("FAIL random status cyc %0d: got %b want %b", i, stat_a,
                         exp_status(qa.size(), 6, 5, 1, ovfa, unfa));
            end
            if (qa.size() != 0) begin
                compared++;
                if (rdata_a !== qa[0]) begin
                    mismatched++;
                    $display("FAIL random r_data cyc %0d: got %h want %h", i, rdata_a, qa[0]);
                end
            end
        end
    endtask

    initial begin
        reset_a = 1; flush_a = 0; clr_a = 0; wr_a = 0; rd_a = 0; wdata_a = '0;
        reset_b = 1; flush_b = 0; clr_b = 0; wr_b = 0; rd_b = 0; wdata_b = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_full_wr_rd();
        test_overflow();
        test_empty_wr_rd();
        test_flush();
        test_size5();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Synchronous single-clock FIFO. Generalises the UART buffer FIFO with:
- any depth ≥ 2, not only powers of two;
- an occupancy count output;
- programmable almost-full and almost-empty flags;
- a synchronous flush;
- sticky overflow and underflow error flags.

It sits between the UART RX/TX datapaths and the debug/loader logic wherever back-pressure thresholds are needed.

Parameters:
FIFO_SIZE, `DEFAULT_FIFO_SIZE, number of words; integer ≥ 2, any value.
WORD_WIDTH, `DEFAULT_FIFO_WORD_WIDTH, bits per word.
AFULL_LEVEL, FIFO_SIZE-1, almost_full asserts when count ≥ AFULL_LEVEL; range 1..FIFO_SIZE.
AEMPTY_LEVEL, 1, almost_empty asserts when count ≤ AEMPTY_LEVEL; range 0..FIFO_SIZE-1.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-high.
flush  in  1  synchronous clear of contents.
clr_err  in  1  clears overflow/underflow.
w_data  in  WORD_WIDTH  write data.
wr  in  1  write request.
rd  in  1  read (pop) request.
r_data  out  WORD_WIDTH  head word, first-word-fall-through.
full  out  1  count == FIFO_SIZE.
empty  out  1  count == 0.
almost_full  out  1  count ≥ AFULL_LEVEL.
almost_empty  out  1  count ≤ AEMPTY_LEVEL.
count  out  $clog2(FIFO_SIZE+1)  current occupancy.
overflow  out  1  sticky: write attempted while full and not accepted.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset values:
  - pointers 0, count 0;
  - empty=1, almost_empty=1, full=0, almost_full=0;
  - overflow=0, underflow=0.
  - r_data is don't-care; memory is not reset.
- Priority: reset > flush > wr/rd.
  - flush sets pointers and count to 0 and recomputes flags for count 0.
  - flush ignores wr/rd in that cycle and does not touch overflow/underflow.
- Pointers wrap explicitly: FIFO_SIZE-1 → 0. No reliance on natural binary overflow.
- r_data = mem[r_ptr], combinational. It is valid whenever empty=0.
- rd is a pop acknowledge of the currently shown word. The next word is visible the cycle after the pop.
- Accept rules, evaluated on registered state:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd_ok).
- When full, wr&rd in the same cycle are both accepted:
  - the write lands in the slot being freed;
  - count stays FIFO_SIZE;
  - overflow is not set;
  - r_data shows the old word that cycle.
- When empty, wr&rd in the same cycle:
  - the write is accepted and the read ignored;
  - count → 1;
  - underflow is set.
- Count update: count_next = count + wr_ok − rd_ok. It never exceeds FIFO_SIZE and never goes below 0.
- All four level flags are registered from count_next. No combinational path from wr/rd to any flag.
- overflow sets on wr & ~wr_ok. underflow sets on rd & ~rd_ok.
- Both error flags hold until reset or clr_err.
  - If clr_err coincides with a new error event, the flag ends set (set wins).
- Write latency: data written in cycle N appears on r_data in cycle N+1 if the FIFO was empty.
- Reset mid-traffic discards all contents. wr/rd in the reset cycle have no effect.

Decomposition:
- fifo.vh: FIFO state encodings `FIFO_STATE_READ / _WRITE / _READ_AND_WRITE (reused), plus `FIFO_COUNT_WIDTH(n) macro.
- common.vh: `LOW, `HIGH, `CLEAR.
- Sub-module fifo_ptr: wrapping pointer register with inc enable, sync clear, and parameter FIFO_SIZE. Instantiated twice, for write and read.

Test Plan:
(FIFO_SIZE=6, WORD_WIDTH=8, AFULL_LEVEL=5, AEMPTY_LEVEL=1 unless noted.)
1. Reset, then write 0x11..0x16 on consecutive cycles.
   → count 1..6; almost_empty drops when count=2; almost_full rises when count=5; full=1 when count=6.
   → Then pop 6 times → r_data 0x11..0x16 in order; empty=1 after the last pop.
2. Fill to 6, then 10 cycles of wr&rd with data 0x20..0x29.
   → count stays 6, overflow=0, popped sequence continues FIFO order across the wrap at index 5→0.
3. Full FIFO, wr=1 rd=0 → count stays 6 and overflow=1. Then clr_err pulse → overflow=0.
4. Empty FIFO, wr=1 rd=1, w_data=0xA5.
   → next cycle count=1, r_data=0xA5, underflow=1.
5. Load 4 words, assert flush together with wr=1 rd=1.
   → next cycle count=0, empty=1, almost_empty=1; overflow/underflow unchanged.
6. FIFO_SIZE=5 (non-power-of-two): 3 full fill/drain rounds.
   → data integrity intact, pointer wrap at 4→0, full only at count=5.
